// File: rtl/lif_spike_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : lif_spike_decoder_if
// Purpose  : Result channel of the LIF spike decoder. Carries the per-window
//            statistics from the decoder (master) to a readout (slave) with
//            a valid/ready handshake.
// Signals  : out_valid  - result holds an unconsumed window (master -> slave)
//            out_ready  - consumer accepts the result       (slave -> master)
//            spike_cnt  - spikes in the completed window
//            isi_min    - minimum ISI in the window, all-ones if none
//            refr_cnt   - enabled cycles with refractory=1 in the window
// Revision : 1.0 - initial release
// ============================================================================
interface lif_spike_decoder_if #(
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
) ();
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] spike_cnt;
  logic [ISI_W-1:0] isi_min;
  logic [CNT_W-1:0] refr_cnt;

  modport master (
    output out_valid,
    output spike_cnt,
    output isi_min,
    output refr_cnt,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  spike_cnt,
    input  isi_min,
    input  refr_cnt,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/lif_spike_decoder.sv
`default_nettype none
// ============================================================================
// Module   : lif_spike_decoder
// Purpose  : Decodes the spike train of a LIF neuron into per-window
//            statistics (spike count, minimum inter-spike interval,
//            refractory occupancy) and tracks the live last ISI.
// Ports    : clk, rst_n     - clock, asynchronous active-low reset
//            en             - sample enable shared with the neuron
//            clr            - synchronous clear to reset values
//            win_len        - window length in enabled cycles, 0 = off
//            spike          - neuron spike pulse
//            refractory     - neuron refractory flag
//            res            - result channel (master modport)
//            isi_last       - most recent captured ISI
//            drop           - sticky, a completed window was discarded
//            busy           - a window is in progress
// Revision : 1.0 - initial release
// ============================================================================
module lif_spike_decoder #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              en,
  input  wire logic              clr,
  input  wire logic [WIN_W-1:0]  win_len,
  input  wire logic              spike,
  input  wire logic              refractory,
  lif_spike_decoder_if.master    res,
  output logic      [ISI_W-1:0]  isi_last,
  output logic                   drop,
  output logic                   busy
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [ISI_W-1:0] c_isi_max = {ISI_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIN_W-1:0]   r_win_q;
  logic [WIN_W-1:0]   r_win_ctr;
  logic [CNT_W-1:0]   r_spike_acc;
  logic [CNT_W-1:0]   r_refr_acc;
  logic [ISI_W-1:0]   r_min_acc;
  logic [ISI_W-1:0]   r_isi_ctr;
  logic               r_have_spike;

  logic               r_out_valid;
  logic [CNT_W-1:0]   r_spike_cnt;
  logic [ISI_W-1:0]   r_isi_min;
  logic [CNT_W-1:0]   r_refr_cnt;
  logic [ISI_W-1:0]   r_isi_last;
  logic               r_drop;

  logic               w_start;
  logic               w_in_win;
  logic               w_last;
  logic               w_capture;
  logic [WIN_W-1:0]   w_cur_ctr;
  logic [WIN_W-1:0]   w_cur_len;
  logic [ISI_W-1:0]   w_isi_inc;
  logic [CNT_W-1:0]   w_spike_base;
  logic [CNT_W-1:0]   w_refr_base;
  logic [ISI_W-1:0]   w_min_base;
  logic [CNT_W-1:0]   w_spike_nxt;
  logic [CNT_W-1:0]   w_refr_nxt;
  logic [ISI_W-1:0]   w_min_nxt;

  // --------------------------------------------------------------------------
  // Window control and accumulator next values. The IDLE cycle that starts a
  // window is itself window cycle 0, so in IDLE the "current" counter,
  // length and accumulators are taken as the fresh-window values. This also
  // makes win_len=1 publish on the start cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_start      = (r_state == ST_IDLE) && en && (win_len != '0);
    w_in_win     = ((r_state == ST_RUN) && en) || w_start;
    w_cur_ctr    = (r_state == ST_IDLE) ? '0      : r_win_ctr;
    w_cur_len    = (r_state == ST_IDLE) ? win_len : r_win_q;
    w_last       = w_in_win && (w_cur_ctr == (w_cur_len - WIN_W'(1)));

    // Saturating increment doubles as the captured ISI (isi_ctr + 1).
    w_isi_inc    = (r_isi_ctr == c_isi_max) ? c_isi_max : (r_isi_ctr + ISI_W'(1));
    w_capture    = spike && r_have_spike;

    w_spike_base = (r_state == ST_IDLE) ? '0        : r_spike_acc;
    w_refr_base  = (r_state == ST_IDLE) ? '0        : r_refr_acc;
    w_min_base   = (r_state == ST_IDLE) ? c_isi_max : r_min_acc;

    w_spike_nxt  = (spike && (w_spike_base != c_cnt_max)) ?
                   (w_spike_base + CNT_W'(1)) : w_spike_base;
    w_refr_nxt   = (refractory && (w_refr_base != c_cnt_max)) ?
                   (w_refr_base + CNT_W'(1)) : w_refr_base;
    w_min_nxt    = (w_capture && (w_isi_inc < w_min_base)) ? w_isi_inc : w_min_base;

    if (clr) begin
      w_state_nxt = ST_IDLE;
    end else if (w_last) begin
      w_state_nxt = (win_len == '0) ? ST_IDLE : ST_RUN;
    end else if (w_start) begin
      w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: ISI tracking, accumulators and the result register.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_q      <= '0;
      r_win_ctr    <= '0;
      r_spike_acc  <= '0;
      r_refr_acc   <= '0;
      r_min_acc    <= c_isi_max;
      r_isi_ctr    <= '0;
      r_have_spike <= 1'b0;
      r_out_valid  <= 1'b0;
      r_spike_cnt  <= '0;
      r_isi_min    <= c_isi_max;
      r_refr_cnt   <= '0;
      r_isi_last   <= '0;
      r_drop       <= 1'b0;
    end else if (clr) begin
      r_win_q      <= '0;
      r_win_ctr    <= '0;
      r_spike_acc  <= '0;
      r_refr_acc   <= '0;
      r_min_acc    <= c_isi_max;
      r_isi_ctr    <= '0;
      r_have_spike <= 1'b0;
      r_out_valid  <= 1'b0;
      r_spike_cnt  <= '0;
      r_isi_min    <= c_isi_max;
      r_refr_cnt   <= '0;
      r_isi_last   <= '0;
      r_drop       <= 1'b0;
    end else begin
      // ISI runs continuously, independent of the window state.
      if (en) begin
        if (spike) begin
          r_isi_ctr    <= '0;
          r_have_spike <= 1'b1;
          if (r_have_spike) begin
            r_isi_last <= w_isi_inc;
          end
        end else begin
          r_isi_ctr <= w_isi_inc;
        end
      end

      if (w_last) begin
        // A pending result being drained this cycle frees the slot.
        if (!r_out_valid || res.out_ready) begin
          r_out_valid <= 1'b1;
          r_spike_cnt <= w_spike_nxt;
          r_isi_min   <= w_min_nxt;
          r_refr_cnt  <= w_refr_nxt;
        end else begin
          r_drop <= 1'b1;
        end
        r_win_q     <= win_len;
        r_win_ctr   <= '0;
        r_spike_acc <= '0;
        r_refr_acc  <= '0;
        r_min_acc   <= c_isi_max;
      end else begin
        if (r_out_valid && res.out_ready) begin
          r_out_valid <= 1'b0;
        end
        if (w_in_win) begin
          r_win_ctr   <= w_cur_ctr + WIN_W'(1);
          r_spike_acc <= w_spike_nxt;
          r_refr_acc  <= w_refr_nxt;
          r_min_acc   <= w_min_nxt;
          if (w_start) begin
            r_win_q <= win_len;
          end
        end
      end
    end
  end

  assign res.out_valid = r_out_valid;
  assign res.spike_cnt = r_spike_cnt;
  assign res.isi_min   = r_isi_min;
  assign res.refr_cnt  = r_refr_cnt;
  assign isi_last      = r_isi_last;
  assign drop          = r_drop;
  assign busy          = (r_state == ST_RUN);

endmodule
`default_nettype wire
